// File: rtl/ps2_key_pkg.sv
// Shared constants and FSM encoding for the PS/2 key sequencer.
package ps2_key_pkg;
   localparam logic [7:0] PS2_EXT     = 8'hE0;
   localparam logic [7:0] PS2_BRK     = 8'hF0;
   localparam int         NUM_WATCHED = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_CAP  = 2'd2
   } seq_state_t;
endpackage

// File: rtl/key_repeat_unit.sv
// Held bit and move-pulse generator for one watched key.
// Optional auto-repeat counter under `AUTOREPEAT_EN.
module key_repeat_unit #(
   parameter int REPEAT_DELAY  = 6250000,
   parameter int REPEAT_PERIOD = 2500000
) (
   input  logic clk,
   input  logic rst,
   input  logic match_make,
   input  logic match_brk,
   output logic held,
   output logic pulse
);

   logic r_held;
   logic r_pulse;
   logic w_press;

   assign w_press = match_make & ~r_held;
   assign held    = r_held;
   assign pulse   = r_pulse;

`ifdef AUTOREPEAT_EN
   localparam int MAXR = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW   = $clog2(MAXR + 1);
   localparam logic [CW-1:0] DLY_M1 = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_M1 = CW'(REPEAT_PERIOD - 1);

   logic [CW-1:0] r_cnt;
   logic          r_first;
   logic          w_tick;

   assign w_tick = r_held & (r_cnt == (r_first ? DLY_M1 : PER_M1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_held  <= 1'b0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
         r_first <= 1'b0;
      end else begin
         // a break landing on a repeat tick suppresses that tick
         r_pulse <= w_press | (w_tick & ~match_brk);
         if (match_brk)
            r_held <= 1'b0;
         else if (match_make)
            r_held <= 1'b1;
         if (w_press | match_brk | w_tick)
            r_cnt <= '0;
         else if (r_held)
            r_cnt <= r_cnt + 1'b1;
         if (w_press)
            r_first <= 1'b1;
         else if (w_tick)
            r_first <= 1'b0;
      end
   end
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_held  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_pulse <= w_press;
         if (match_brk)
            r_held <= 1'b0;
         else if (match_make)
            r_held <= 1'b1;
      end
   end
`endif

endmodule

// File: rtl/ps2_key_sequencer.sv
// Drains the PS/2 receive FIFO and decodes set-2 scan codes (E0/F0 prefixes)
// into key events plus held/pulse state for three watched keys. Macro: AUTOREPEAT_EN.
module ps2_key_sequencer
   import ps2_key_pkg::*;
#(
   parameter logic [7:0] KEY0           = 8'h34,
   parameter logic [7:0] KEY1           = 8'h36,
   parameter logic [7:0] KEY2           = 8'h32,
   parameter int         PREFIX_TIMEOUT = 2500000,
   parameter int         REPEAT_DELAY   = 6250000,
   parameter int         REPEAT_PERIOD  = 2500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_make,
   output logic [2:0] key_held,
   output logic [2:0] key_pulse
);

   localparam int PTW = $clog2(PREFIX_TIMEOUT + 1);
   localparam logic [PTW-1:0] PTO_M1 = PTW'(PREFIX_TIMEOUT - 1);
   localparam logic [NUM_WATCHED*8-1:0] KEYS = {KEY2, KEY1, KEY0};

   seq_state_t r_state;
   seq_state_t w_state_nxt;
   logic       w_fifo_rd;
   logic       w_cap;

   logic           r_ext;
   logic           r_brk;
   logic [PTW-1:0] r_pto_cnt;
   logic           r_key_valid;
   logic [7:0]     r_key_code;
   logic           r_key_ext;
   logic           r_key_make;

   logic                   w_byte_event;
   logic                   w_plain;
   logic [NUM_WATCHED-1:0] w_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fifo_rd   = 1'b0;
      w_cap       = 1'b0;
      case (r_state)
         ST_IDLE: if (!fifo_empty) w_state_nxt = ST_RD;
         ST_RD: begin
            w_fifo_rd   = 1'b1;
            w_state_nxt = ST_CAP;
         end
         ST_CAP: begin
            w_cap       = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign fifo_rd = w_fifo_rd;

   assign w_byte_event = w_cap & (fifo_data != PS2_EXT) & (fifo_data != PS2_BRK);
   assign w_plain      = w_byte_event & ~r_ext;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ext       <= 1'b0;
         r_brk       <= 1'b0;
         r_pto_cnt   <= '0;
         r_key_valid <= 1'b0;
         r_key_code  <= 8'h00;
         r_key_ext   <= 1'b0;
         r_key_make  <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (w_cap) begin
            r_pto_cnt <= '0;
            if (fifo_data == PS2_EXT)
               r_ext <= 1'b1;
            else if (fifo_data == PS2_BRK)
               r_brk <= 1'b1;
            else begin
               r_key_valid <= 1'b1;
               r_key_code  <= fifo_data;
               r_key_ext   <= r_ext;
               r_key_make  <= ~r_brk;
               r_ext       <= 1'b0;
               r_brk       <= 1'b0;
            end
         end else if (r_ext | r_brk) begin
            // a stranded prefix must not taint an unrelated later byte
            if (r_pto_cnt == PTO_M1) begin
               r_ext     <= 1'b0;
               r_brk     <= 1'b0;
               r_pto_cnt <= '0;
            end else begin
               r_pto_cnt <= r_pto_cnt + 1'b1;
            end
         end
      end
   end

   assign key_valid = r_key_valid;
   assign key_code  = r_key_code;
   assign key_ext   = r_key_ext;
   assign key_make  = r_key_make;

   for (genvar gi = 0; gi < NUM_WATCHED; gi++) begin : g_key
      assign w_hit[gi] = w_plain & (fifo_data == KEYS[gi*8 +: 8]);

      key_repeat_unit #(
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_key (
         .clk        (clk),
         .rst        (rst),
         .match_make (w_hit[gi] & ~r_brk),
         .match_brk  (w_hit[gi] & r_brk),
         .held       (key_held[gi]),
         .pulse      (key_pulse[gi])
      );
   end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed, table-driven bench for ps2_key_sequencer with a small FIFO model.
module tb_ps2_key_sequencer;

   localparam int PT = 30;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       fifo_empty;
   logic [7:0] fifo_data = 8'h00;
   logic       fifo_rd;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_make;
   logic [2:0] key_held;
   logic [2:0] key_pulse;

   ps2_key_sequencer #(
      .PREFIX_TIMEOUT (PT),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd    (fifo_rd),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ext    (key_ext),
      .key_make   (key_make),
      .key_held   (key_held),
      .key_pulse  (key_pulse)
   );

   always #5 clk = ~clk;

   // FIFO model: data appears the cycle after the pop strobe
   logic [7:0] mem [0:255];
   int wp = 0;
   int rp = 0;
   assign fifo_empty = (wp == rp);

   always @(posedge clk) begin
      if (fifo_rd) begin
         fifo_data <= mem[rp[7:0]];
         rp        <= rp + 1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // event monitor
   int         ev_n = 0;
   logic [7:0] last_code = 8'h00;
   logic       last_ext = 1'b0;
   logic       last_make = 1'b0;
   int         press_cnt [3] = '{0, 0, 0};
   int         rep_cnt [3] = '{0, 0, 0};
   int         rep_log [0:63];
   int         rep_n = 0;
   int         rd_double = 0;
   logic       prev_rd = 1'b0;

   always @(negedge clk) begin
      if (fifo_rd && prev_rd) rd_double = rd_double + 1;
      prev_rd = fifo_rd;
      if (rst) begin
         if (key_valid) begin
            ev_n      = ev_n + 1;
            last_code = key_code;
            last_ext  = key_ext;
            last_make = key_make;
         end
         for (int i = 0; i < 3; i++) begin
            if (key_pulse[i]) begin
               if (key_valid) press_cnt[i] = press_cnt[i] + 1;
               else begin
                  rep_cnt[i] = rep_cnt[i] + 1;
                  if (i == 0 && rep_n < 64) begin
                     rep_log[rep_n] = cyc;
                     rep_n = rep_n + 1;
                  end
               end
            end
         end
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wp[7:0]] = b;
      wp = wp + 1;
   endtask

   task automatic wait_cyc(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   typedef struct {
      logic [31:0] bytes;
      int          n;
      int          nev;
      logic [7:0]  code;
      logic        ext;
      logic        make;
      logic [2:0]  held;
      logic [2:0]  press;
   } vec_t;

   vec_t vecs [10];

   task automatic setv(input int idx, input logic [31:0] b, input int n, input int nev,
                       input logic [7:0] code, input logic ext, input logic make,
                       input logic [2:0] held, input logic [2:0] press);
      vecs[idx].bytes = b;
      vecs[idx].n     = n;
      vecs[idx].nev   = nev;
      vecs[idx].code  = code;
      vecs[idx].ext   = ext;
      vecs[idx].make  = make;
      vecs[idx].held  = held;
      vecs[idx].press = press;
   endtask

   int ev0;
   int pc0 [3];
   int rp0;
   int p_cyc;
   logic found;

   initial begin
      setv(0, 32'h1C000000, 1, 1, 8'h1C, 1'b0, 1'b1, 3'b000, 3'b000);
      setv(1, 32'h34000000, 1, 1, 8'h34, 1'b0, 1'b1, 3'b001, 3'b001);
      setv(2, 32'hF0340000, 2, 1, 8'h34, 1'b0, 1'b0, 3'b000, 3'b000);
      setv(3, 32'hE0F07500, 3, 1, 8'h75, 1'b1, 1'b0, 3'b000, 3'b000);
      setv(4, 32'hE0340000, 2, 1, 8'h34, 1'b1, 1'b1, 3'b000, 3'b000);
      setv(5, 32'h36363600, 3, 3, 8'h36, 1'b0, 1'b1, 3'b010, 3'b010);
      setv(6, 32'hF0E03600, 3, 1, 8'h36, 1'b1, 1'b0, 3'b010, 3'b000);
      setv(7, 32'h32340000, 2, 2, 8'h34, 1'b0, 1'b1, 3'b111, 3'b101);
      setv(8, 32'hF036F032, 4, 2, 8'h32, 1'b0, 1'b0, 3'b001, 3'b000);
      setv(9, 32'hF0340000, 2, 1, 8'h34, 1'b0, 1'b0, 3'b000, 3'b000);

      // reset state
      wait_cyc(3);
      chk("rst_fifo_rd", fifo_rd, 0);
      chk("rst_valid", key_valid, 0);
      chk("rst_code", key_code, 0);
      chk("rst_held", key_held, 0);
      chk("rst_pulse", key_pulse, 0);
      rst = 1'b1;
      wait_cyc(2);

      // read latency
      push(8'h1C);
      @(negedge clk);
      chk("lat_rd_a1", fifo_rd, 1);
      @(negedge clk);
      chk("lat_rd_a2", fifo_rd, 0);
      chk("lat_vld_a2", key_valid, 0);
      @(negedge clk);
      chk("lat_vld_a3", key_valid, 1);
      chk("lat_code", key_code, 8'h1C);
      chk("lat_ext", key_ext, 0);
      chk("lat_make", key_make, 1);
      @(negedge clk);
      chk("lat_vld_a4", key_valid, 0);
      chk("lat_code_hold", key_code, 8'h1C);
      wait_cyc(2);

      // table
      for (int v = 0; v < 10; v++) begin
         ev0 = ev_n;
         for (int i = 0; i < 3; i++) pc0[i] = press_cnt[i];
         for (int k = 0; k < vecs[v].n; k++) push(vecs[v].bytes[31-8*k -: 8]);
         wait_cyc(3 * vecs[v].n + 4);
         chk($sformatf("v%0d_nev", v), ev_n - ev0, vecs[v].nev);
         chk($sformatf("v%0d_code", v), last_code, vecs[v].code);
         chk($sformatf("v%0d_ext", v), last_ext, vecs[v].ext);
         chk($sformatf("v%0d_make", v), last_make, vecs[v].make);
         chk($sformatf("v%0d_held", v), key_held, vecs[v].held);
         for (int i = 0; i < 3; i++)
            chk($sformatf("v%0d_press%0d", v, i), press_cnt[i] - pc0[i], vecs[v].press[i]);
      end
`ifndef AUTOREPEAT_EN
      chk("no_repeat", rep_cnt[0] + rep_cnt[1] + rep_cnt[2], 0);
`endif

      // prefix still alive after half the timeout
      push(8'hE0);
      wait_cyc(PT / 2);
      ev0 = ev_n;
      push(8'h75);
      wait_cyc(6);
      chk("pto_early_nev", ev_n - ev0, 1);
      chk("pto_early_ext", last_ext, 1);

      // prefix expired
      push(8'hE0);
      wait_cyc(PT + 8);
      ev0 = ev_n;
      pc0[2] = press_cnt[2];
      push(8'h32);
      wait_cyc(6);
      chk("pto_nev", ev_n - ev0, 1);
      chk("pto_code", last_code, 8'h32);
      chk("pto_ext", last_ext, 0);
      chk("pto_pulse2", press_cnt[2] - pc0[2], 1);
      push(8'hF0);
      push(8'h32);
      wait_cyc(10);
      chk("pto_rel_held", key_held, 0);

      // reset in the middle of a read
      push(8'h36);
      wait_cyc(6);
      push(8'h34);
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         @(negedge clk);
         if (fifo_rd) found = 1'b1;
      end
      chk("mr_rd_seen", found, 1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mr_valid", key_valid, 0);
      chk("mr_code", key_code, 0);
      chk("mr_make", key_make, 0);
      chk("mr_held", key_held, 0);
      chk("mr_pulse", key_pulse, 0);
      chk("mr_fifo_rd", fifo_rd, 0);
      wait_cyc(2);
      ev0 = ev_n;
      rst = 1'b1;
      wait_cyc(12);
      chk("mr_no_event", ev_n - ev0, 0);
      chk("mr_held_after", key_held, 0);

`ifdef AUTOREPEAT_EN
      rp0 = rep_n;
      push(8'h34);
      found = 1'b0;
      p_cyc = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (key_pulse[0] && key_valid) begin
            found = 1'b1;
            p_cyc = cyc;
         end
      end
      chk("ar_press", found, 1);
      while (cyc < p_cyc + 38) @(negedge clk);
      push(8'hF0);
      push(8'h34);
      wait_cyc(40);
      chk("ar_count", rep_n - rp0, 3);
      chk("ar_off0", rep_log[rp0] - p_cyc, 20);
      chk("ar_off1", rep_log[rp0 + 1] - p_cyc, 28);
      chk("ar_off2", rep_log[rp0 + 2] - p_cyc, 36);
      chk("ar_rel_make", last_make, 0);
      chk("ar_rel_held", key_held, 0);
`endif

      chk("rd_never_double", rd_double, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
- Drains the ps2_if receive FIFO one byte at a time and decodes PS/2 set-2 scan codes, including E0 (extended) and F0 (break) prefixes, into single-cycle key events.
- Tracks press/hold state for three watched game keys and emits move pulses for them.
- Sits between ps2_if and TETRIS_GAME.
- Replaces the ad-hoc FIFO-read and prefix logic in top_level and the three button_machine instances.

Parameters:
- KEY0, 8'h34, scan code of watched key 0 (left)
- KEY1, 8'h36, scan code of watched key 1 (right)
- KEY2, 8'h32, scan code of watched key 2 (down)
- PREFIX_TIMEOUT, 2500000, cycles a pending E0/F0 prefix survives without a following byte (100 ms at 25 MHz)
- REPEAT_DELAY, 6250000, cycles from press to the first auto-repeat pulse (used only with AUTOREPEAT_EN)
- REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeat pulses (used only with AUTOREPEAT_EN)

Ports:
- clk  in  1  25 MHz system clock
- rst  in  1  asynchronous, active-low reset
- fifo_empty  in  1  ps2_if status[0]; 1 = FIFO empty
- fifo_data  in  8  ps2_if data[7:0]; valid the cycle after fifo_rd
- fifo_rd  out  1  one-cycle pop strobe to ps2_if
- key_valid  out  1  one-cycle event strobe
- key_code  out  8  scan code of the event; held until the next event
- key_ext  out  1  event was E0-prefixed
- key_make  out  1  1 = press, 0 = release
- key_held  out  3  level: watched key i currently down
- key_pulse  out  3  one-cycle move pulse per watched key

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0, the FSM goes to IDLE, and the ext/brk flags, held bits and all counters clear. This applies mid-byte too: a byte being read is discarded, not replayed.
- FSM states: IDLE, RD, CAP.
  - IDLE and fifo_empty=0: next cycle fifo_rd=1, go to RD.
  - RD: fifo_rd returns to 0, go to CAP.
  - CAP: sample fifo_data, decode it, return to IDLE.
- Read latency: fifo_empty low seen in IDLE at cycle A → fifo_rd high at A+1 → byte sampled at A+2 → key_valid/key_pulse high at A+3.
- Throughput: IDLE at A+3 can start the next read immediately, so one byte per 3 cycles. fifo_rd is never high for two consecutive cycles.
- Decode in CAP:
  - 8'hE0: set ext; no event.
  - 8'hF0: set brk; no event.
  - Any other byte: key_valid=1, key_code=byte, key_ext=ext, key_make=~brk; then clear ext and brk.
  - E0 F0 xx yields an extended release. F0 E0 xx is accepted the same way.
- Prefix timeout: an 8-bit-independent counter runs while ext or brk is set. It reaches PREFIX_TIMEOUT → clear both flags, no event. Any byte captured restarts the count.
- Watched keys: match only when key_ext=0 and key_code=KEYi.
  - Make while held[i]=0: set held[i], key_pulse[i]=1 in the same cycle as key_valid.
  - Make while held[i]=1: keyboard typematic repeat; ignored, no pulse.
  - Break: clear held[i], no pulse.
- The three keys are independent; any combination may be held at once.
- key_pulse and key_valid are registered outputs, each high for exactly one cycle.

Optional Feature:
- Macro: AUTOREPEAT_EN
- Defined: each watched key has a repeat counter that runs while held[i]=1.
  - First extra pulse when the counter reaches REPEAT_DELAY cycles after the press pulse, then one every REPEAT_PERIOD cycles.
  - The counter resets on press and on break.
  - A break arriving in the same cycle as a repeat tick wins: no pulse.
- Undefined: key_pulse fires only on the initial press; no repeat counters are synthesised.

Decomposition:
- Package ps2_key_pkg:
  - PS2_EXT=8'hE0, PS2_BRK=8'hF0
  - FSM state encoding (IDLE/RD/CAP)
  - NUM_WATCHED=3
- Sub-module key_repeat_unit, instantiated once per watched key. Contains the held bit, the press-edge pulse, and (under AUTOREPEAT_EN) the repeat counter.
  - Inputs: match_make, match_brk.
  - Outputs: held, pulse.

Test Plan:
- FIFO holds 8'h1C; empty deasserts at cycle A → fifo_rd high at A+1 only; key_valid at A+3 with code=1C, ext=0, make=1.
- Bytes F0 34 → one event (code=34, make=0); held[0] clears; no pulse. Preceded by 34 → exactly one key_pulse[0] on the press.
- Bytes E0 F0 75 → one event (code=75, ext=1, make=0). Bytes E0 34 → no watched-key effect.
- Bytes 36 36 36 (typematic) → one key_pulse[1]; held[1] stays 1.
- Byte E0, then PREFIX_TIMEOUT cycles of silence, then 32 → event with ext=0; key_pulse[2]=1.
- AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=8: press 34, hold → extra pulses at +20, +28, +36 cycles; break at +44 → none after. Assert rst low mid-read → all outputs 0 at once; no stale event after release.
